pu_stream_driver: RTL
=====================

Name: pu_stream_driver

Overview:
- Initiator side of the 4-lane processing-unit (PU) datapath.
- Buffers up to DEPTH operand vectors, each holding 4 inputs and 4 weights, then issues one vector per cycle onto the PU operand ports.
- Tracks the PU's fixed pipeline latency with a tag shift register and returns each 12-bit PU result, tagged with its vector index.
- Sits between the layer controller/memory loader and one PU instance.

Parameters:
- DEPTH, 8, number of operand vectors buffered (power of two, at least 2).
- DW, 5, width of each input and weight lane.
- RW, 12, PU result width.
- LAT, 2, PU latency: cycles from operands presented to the valid PU output.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-low reset.
- ld_valid  in  1  load request for one operand vector.
- ld_ready  out  1  buffer accepts a vector; a vector transfers when ld_valid and ld_ready are both high.
- ld_data  in  8*DW  {w4,w3,w2,w1,x4,x3,x2,x1}, with x1 in the LSBs.
- start  in  1  begin issuing the buffered vectors.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last result is returned.
- pu_in1..pu_in4  out  DW each  PU input lanes.
- pu_w1..pu_w4  out  DW each  PU weight lanes.
- pu_out  in  RW  PU result.
- res_valid  out  1  res_data/res_idx valid this cycle.
- res_data  out  RW  captured PU result.
- res_idx  out  clog2(DEPTH)  index of the vector that produced res_data.

Behaviour:
- Reset (rst==0 at an edge) clears the following:
  - state to IDLE;
  - stored count to 0 and issue pointer to 0;
  - tag shift register cleared;
  - all pu_* outputs to 0;
  - res_valid=0, res_data=0, res_idx=0, done=0, busy=0.
- Reset mid-RUN/DRAIN discards all in-flight tags; no res_valid follows.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - ld_ready = (count < DEPTH).
  - An accepted vector is written at address count, then count++.
  - ld_valid while count==DEPTH is ignored (ld_ready=0); no overwrite.
  - start with count>0 -> RUN on the next edge. start with count==0 is ignored.
  - If start and a load handshake occur in the same cycle, the load is accepted first; the new vector is included in the run.
- RUN:
  - ld_ready=0 and busy=1.
  - In RUN cycle k (k=0..count-1), pu_* carry vector k, and a tag {valid=1, idx=k} enters the tag shift register.
  - After vector count-1 has been issued -> DRAIN.
  - start is ignored while busy.
- DRAIN:
  - pu_* are held at 0 and zero tags are shifted in.
  - When the tag register is empty and no result is pending -> DONE.
- DONE: done=1 for exactly one cycle, count is cleared to 0, then -> IDLE.
- Result path:
  - The tag register is LAT stages deep.
  - When the valid tag exits the last stage (cycle k+LAT), pu_out is captured into res_data on that edge.
  - res_valid=1 and res_idx=k are asserted in cycle k+LAT+1 for one cycle.
  - Results appear in strictly increasing idx order, back-to-back with no gaps.
- Throughput: one vector per cycle; there is no backpressure on results.
- Total latency, start to done: count+LAT+2 cycles.
- Operand buffer: DEPTH x 8*DW register array, read combinationally by the issue pointer.
- Lanes are unsigned, and the driver does no arithmetic on results.

Optional Feature:
- Macro: PU_RESULT_ACCUM_EN.
- When defined:
  - Adds output acc_out, width RW+clog2(DEPTH).
  - acc_out is cleared on reset and on entry to RUN.
  - acc_out += res_data on every res_valid cycle.
  - acc_out holds its final sum from DONE until the next start.
  - There is no overflow, because the width covers DEPTH maximal results.
- When not defined: the acc_out port and the accumulator logic do not exist.

Test Plan:
- Load 1 vector (x=1,2,3,4; w=1,1,1,1), start, behavioural PU (registered sum of products, LAT=2) -> res_valid in cycle 3 after RUN entry with res_data=10, res_idx=0; done pulses the following cycle.
- Load 8 vectors, vector k all lanes = k+1 with weights 1 -> 8 consecutive res_valid with res_data=4*(k+1), idx 0..7; ld_ready=0 after the 8th load.
- Attempt a 9th load with ld_valid held -> not accepted, count stays 8; all lanes=31, weights=31 -> res_data=3844 (no truncation at RW=12).
- start with empty buffer -> state stays IDLE, busy=0, no done.
- Reset asserted in the 2nd RUN cycle of a 4-vector run -> zero res_valid afterward, count=0, ld_ready=1 next cycle.
- PU_RESULT_ACCUM_EN: 3 vectors giving results 10, 20, 30 -> acc_out=60 at done; a new start clears acc_out to 0.

Source files
------------

// File: rtl/pu_stream_driver.sv
// pu_stream_driver: initiator side of the 4-lane PU datapath.
//
// Buffers up to DEPTH operand vectors ({w4,w3,w2,w1,x4,x3,x2,x1}, x1 in the
// LSBs). On start it issues one vector per cycle onto the PU operand lanes,
// tracks the PU pipeline latency with a LAT-deep tag shift register, and
// returns each PU result together with the index of the vector that made it.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   ld_valid/ld_ready    operand vector load handshake, ld_data payload
//   start                begin issuing the buffered vectors
//   busy, done           busy in RUN/DRAIN, done is a one-cycle pulse
//   pu_in1..4, pu_w1..4  PU operand lanes (zero when not issuing)
//   pu_out               PU result, valid LAT cycles after its operands
//   res_valid/data/idx   captured result and its vector index
//   acc_out              running sum of results (only with PU_RESULT_ACCUM_EN)
//
// Optional feature macro: PU_RESULT_ACCUM_EN
//
// state | meaning
// IDLE  | accept loads, wait for start with a non-empty buffer
// RUN   | issue vector ptr each cycle, push a valid tag
// DRAIN | lanes at zero, wait for the last tag to leave the pipeline
// DONE  | one-cycle done pulse, clear the stored count
module pu_stream_driver #(
  parameter int DEPTH = 8,
  parameter int DW    = 5,
  parameter int RW    = 12,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [8*DW-1:0]          ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [DW-1:0]            pu_in1,
  output logic [DW-1:0]            pu_in2,
  output logic [DW-1:0]            pu_in3,
  output logic [DW-1:0]            pu_in4,
  output logic [DW-1:0]            pu_w1,
  output logic [DW-1:0]            pu_w2,
  output logic [DW-1:0]            pu_w3,
  output logic [DW-1:0]            pu_w4,
  input  logic [RW-1:0]            pu_out,
  output logic                     res_valid,
  output logic [RW-1:0]            res_data,
  output logic [$clog2(DEPTH)-1:0] res_idx
`ifdef PU_RESULT_ACCUM_EN
  ,
  output logic [RW+$clog2(DEPTH)-1:0] acc_out
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [IW-1:0]   ptr;
  logic [8*DW-1:0] mem [DEPTH];
  logic [8*DW-1:0] vec;
  logic [LAT-1:0]  tag_vld;
  logic [IW-1:0]   tag_idx [LAT];
  logic            ld_fire;
  logic            last_issue;
  logic            tags_empty;

  assign ld_ready   = (state == S_IDLE) && (count < DEPTH_C);
  assign ld_fire    = ld_valid && ld_ready;
  assign last_issue = ({1'b0, ptr} == (count - CW'(1)));
  assign tags_empty = (tag_vld == '0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // a load in the start cycle counts, so a buffer that is empty
        // until this very edge still launches a run
        if (start && ((count != '0) || ld_fire))
          state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_issue)
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tags_empty)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          ptr <= '0;
          if (ld_fire)
            count <= count + CW'(1);
        end
        S_RUN: begin
          if (!last_issue)
            ptr <= ptr + IW'(1);
        end
        S_DONE: count <= '0;
        default: ;
      endcase
    end
  end

  // operand store has no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    if (ld_fire)
      mem[count[IW-1:0]] <= ld_data;
  end

  assign vec    = (state == S_RUN) ? mem[ptr] : '0;
  assign pu_in1 = vec[1*DW-1:0*DW];
  assign pu_in2 = vec[2*DW-1:1*DW];
  assign pu_in3 = vec[3*DW-1:2*DW];
  assign pu_in4 = vec[4*DW-1:3*DW];
  assign pu_w1  = vec[5*DW-1:4*DW];
  assign pu_w2  = vec[6*DW-1:5*DW];
  assign pu_w3  = vec[7*DW-1:6*DW];
  assign pu_w4  = vec[8*DW-1:7*DW];

  // tag in stage LAT-1 lines up with the PU result for that vector
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++)
        tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= (state == S_RUN);
      tag_idx[0] <= (state == S_RUN) ? ptr : '0;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      res_valid <= tag_vld[LAT-1];
      if (tag_vld[LAT-1]) begin
        res_data <= pu_out;
        res_idx  <= tag_idx[LAT-1];
      end
    end
  end

`ifdef PU_RESULT_ACCUM_EN
  always_ff @(posedge clk) begin
    if (!rst)
      acc_out <= '0;
    else if ((state == S_IDLE) && (state_nxt == S_RUN))
      acc_out <= '0;
    else if (res_valid)
      acc_out <= acc_out + {{IW{1'b0}}, res_data};
  end
`endif

endmodule
